// File: rtl/bitmap_index_sequencer.sv
// Emits the index of every set bit of an accepted bitmap, one per handshake, lowest- or highest-first.
// Optional macro BITMAP_SEQ_BYPASS_EN allows back-to-back bitmaps with no idle bubble.
module bitmap_index_sequencer #(
    parameter int unsigned WIDTH = 32,
    parameter logic        MODE  = 1'b0,
    localparam int unsigned IdxWidth = $clog2(WIDTH),
    localparam int unsigned CntWidth = $clog2(WIDTH + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    input  logic                mask_valid_i,
    output logic                mask_ready_o,
    input  logic [WIDTH-1:0]    mask_i,
    output logic                idx_valid_o,
    input  logic                idx_ready_i,
    output logic [IdxWidth-1:0] idx_o,
    output logic                last_o,
    output logic [CntWidth-1:0] count_o,
    output logic                done_o,
    output logic                busy_o
);

    if (WIDTH < 2) begin : g_width_check
        $error("bitmap_index_sequencer: WIDTH must be >= 2");
    end

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StRun  = 1'b1;

    logic [0:0]          r_state, w_state_nxt;
    logic [WIDTH-1:0]    r_pending, w_pending_nxt;
    logic [CntWidth-1:0] r_count, w_count_nxt;
    logic                r_done, w_done_nxt;

    logic [IdxWidth-1:0] w_idx;
    logic                w_last;
    logic [WIDTH-1:0]    w_clear;
    logic                w_mask_hs;
    logic                w_idx_hs;

    // Leading/trailing-zero count on the pending bits selects the next index.
    always_comb begin
        w_idx = '0;
        if (MODE == 1'b0) begin
            for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
                if (r_pending[i]) w_idx = IdxWidth'(i);
            end
        end else begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (r_pending[i]) w_idx = IdxWidth'(i);
            end
        end
    end

    assign w_last  = ((r_pending & (r_pending - WIDTH'(1))) == '0);
    assign w_clear = WIDTH'(1) << w_idx;

`ifdef BITMAP_SEQ_BYPASS_EN
    assign mask_ready_o = (r_state == StIdle) ? 1'b1 : (idx_ready_i & w_last & ~flush_i);
`else
    assign mask_ready_o = (r_state == StIdle);
`endif

    assign idx_valid_o = (r_state == StRun);
    assign busy_o      = (r_state == StRun);
    assign idx_o       = w_idx;
    assign last_o      = w_last;
    assign count_o     = r_count;
    assign done_o      = r_done;

    assign w_mask_hs = mask_valid_i & mask_ready_o;
    assign w_idx_hs  = idx_valid_o & idx_ready_i;

    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = r_pending;
        w_count_nxt   = r_count;
        w_done_nxt    = 1'b0;
        if (flush_i) begin
            w_state_nxt   = StIdle;
            w_pending_nxt = '0;
        end else if (r_state == StIdle) begin
            if (w_mask_hs) begin
                w_pending_nxt = mask_i;
                w_count_nxt   = '0;
                if (mask_i == '0) w_done_nxt = 1'b1;
                else              w_state_nxt = StRun;
            end
        end else if (w_idx_hs) begin
            w_pending_nxt = r_pending & ~w_clear;
            w_count_nxt   = r_count + CntWidth'(1);
            if (w_last) begin
                w_done_nxt  = 1'b1;
                w_state_nxt = StIdle;
                // Only reachable with bypass: new bitmap replaces the drained one in the same cycle.
                if (w_mask_hs) begin
                    w_pending_nxt = mask_i;
                    w_count_nxt   = '0;
                    if (mask_i != '0) w_state_nxt = StRun;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= StIdle;
            r_pending <= '0;
            r_count   <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
            r_count   <= w_count_nxt;
            r_done    <= w_done_nxt;
        end
    end

endmodule

// File: tb/tb_bitmap_index_sequencer.sv
// Bench for bitmap_index_sequencer: WIDTH=8, both MODE values driven in lockstep,
// checked every cycle against a queue-based model of the expected index order.
module tb_bitmap_index_sequencer;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       mask_valid;
    logic [7:0] mask;
    logic       idx_ready;

    logic       mrdy0, ivld0, last0, done0, busy0;
    logic [2:0] idx0;
    logic [3:0] cnt0;
    logic       mrdy1, ivld1, last1, done1, busy1;
    logic [2:0] idx1;
    logic [3:0] cnt1;

    int n_vec = 0;
    int n_err = 0;

    // Model: expected index sequences still to be issued, per ordering.
    int q0[$];
    int q1[$];
    int m_count = 0;
    bit m_done  = 1'b0;

    bitmap_index_sequencer #(.WIDTH(8), .MODE(1'b0)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .mask_valid_i(mask_valid),
        .mask_ready_o(mrdy0), .mask_i(mask), .idx_valid_o(ivld0), .idx_ready_i(idx_ready),
        .idx_o(idx0), .last_o(last0), .count_o(cnt0), .done_o(done0), .busy_o(busy0)
    );

    bitmap_index_sequencer #(.WIDTH(8), .MODE(1'b1)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .mask_valid_i(mask_valid),
        .mask_ready_o(mrdy1), .mask_i(mask), .idx_valid_o(ivld1), .idx_ready_i(idx_ready),
        .idx_o(idx1), .last_o(last1), .count_o(cnt1), .done_o(done1), .busy_o(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [7:0] m);
        q0.delete();
        q1.delete();
        for (int i = 0; i < 8; i++) if (m[i]) q0.push_back(i);
        for (int i = 7; i >= 0; i--) if (m[i]) q1.push_back(i);
    endtask

    function automatic bit exp_mrdy();
        if (q0.size() == 0) return 1'b1;
`ifdef BITMAP_SEQ_BYPASS_EN
        return idx_ready && (q0.size() == 1) && !flush;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_outputs();
        bit run;
        run = (q0.size() > 0);
        chk("valid0", 32'(ivld0), 32'(run));
        chk("valid1", 32'(ivld1), 32'(run));
        chk("busy0", 32'(busy0), 32'(run));
        chk("busy1", 32'(busy1), 32'(run));
        chk("mrdy0", 32'(mrdy0), 32'(exp_mrdy()));
        chk("mrdy1", 32'(mrdy1), 32'(exp_mrdy()));
        chk("count0", 32'(cnt0), 32'(m_count));
        chk("count1", 32'(cnt1), 32'(m_count));
        chk("done0", 32'(done0), 32'(m_done));
        chk("done1", 32'(done1), 32'(m_done));
        if (run) begin
            chk("idx0", 32'(idx0), 32'(q0[0]));
            chk("idx1", 32'(idx1), 32'(q1[0]));
            chk("last0", 32'(last0), 32'(q0.size() == 1));
            chk("last1", 32'(last1), 32'(q1.size() == 1));
        end
    endtask

    // One clock cycle: drive, check mid-cycle, advance model, step past the edge.
    task automatic cyc(input bit mv, input logic [7:0] m, input bit rdy, input bit fl);
        bit was_run;
        bit was_last;
        mask_valid = mv;
        mask       = m;
        idx_ready  = rdy;
        flush      = fl;
        #4;
        check_outputs();
        was_run = (q0.size() > 0);
        m_done  = 1'b0;
        if (fl) begin
            q0.delete();
            q1.delete();
        end else if (!was_run) begin
            if (mv) begin
                m_count = 0;
                load(m);
                if (m == 8'h00) m_done = 1'b1;
            end
        end else if (rdy) begin
            was_last = (q0.size() == 1);
            void'(q0.pop_front());
            void'(q1.pop_front());
            m_count++;
            if (was_last) begin
                m_done = 1'b1;
`ifdef BITMAP_SEQ_BYPASS_EN
                if (mv) begin
                    m_count = 0;
                    load(m);
                end
`endif
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    initial begin
        rst_n      = 1'b0;
        flush      = 1'b0;
        mask_valid = 1'b0;
        mask       = 8'h00;
        idx_ready  = 1'b0;
        #3;
        check_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Ordering: 2,5,7 (MODE 0) and 7,5,2 (MODE 1).
        cyc(1'b1, 8'hA4, 1'b1, 1'b0);
        idle_cycles(5);

        // Full bitmap: 8 indices, count saturates at WIDTH.
        cyc(1'b1, 8'hFF, 1'b1, 1'b0);
        idle_cycles(10);

        // Backpressure: index held stable for 3 cycles.
        cyc(1'b1, 8'h11, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0);
        idle_cycles(4);

        // Zero mask: done pulse, no index.
        cyc(1'b1, 8'h00, 1'b1, 1'b0);
        idle_cycles(2);

        // Flush after first index, then a fresh bitmap.
        cyc(1'b1, 8'hF0, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b1, 8'h0F, 1'b1, 1'b1);
        cyc(1'b1, 8'h01, 1'b1, 1'b0);
        idle_cycles(3);

`ifdef BITMAP_SEQ_BYPASS_EN
        // Back-to-back bitmaps with no bubble.
        cyc(1'b1, 8'h03, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b1, 8'h80, 1'b1, 1'b0);
        idle_cycles(3);
`endif

        // Async reset mid-run drops the remaining bits.
        cyc(1'b1, 8'hFF, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        m_count = 0;
        m_done  = 1'b0;
        #1;
        check_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_cycles(2);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            logic [7:0] m;
            m = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            cyc(bit'($urandom_range(0, 1)), m, ($urandom_range(0, 9) < 7),
                ($urandom_range(0, 19) == 0));
        end
        idle_cycles(12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
